carry_chain_sequencer: RTL and testbench

//   Drives the operand and carry side of a combinational full_adder and consumes its sum/carry_out.

---
 rtl/carry_chain_sequencer.sv | 122 ++++++++++++
 tb/tb_carry_chain_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/carry_chain_sequencer.sv
// Multi-limb add/subtract sequencer around an external combinational full_adder.
// Limbs are consumed LS first; carry_out is registered between limbs.
module carry_chain_sequencer #(
  parameter  int width     = 16,
  parameter  int MAX_LIMBS = 8,
  localparam int LCW       = $clog2(MAX_LIMBS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             on_off,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             start_sub,
  input  logic [LCW-1:0]   start_limbs,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_a,
  input  logic [width-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_c,
  output logic             out_last,
  output logic             out_carry,
  output logic [width-1:0] adder_a,
  output logic [width-1:0] adder_b,
  output logic             adder_carry_in,
  output logic             adder_carry_listen,
  output logic             adder_on_off,
  input  logic [width-1:0] adder_c,
  input  logic             adder_carry_out
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  typedef struct packed {
    logic [width-1:0] c;
    logic             last;
    logic             carry;
  } res_t;

  state_t         state, state_nxt;
  res_t           res_q;
  logic           out_valid_q;
  logic           sub_q, carry_q, first_q;
  logic [LCW-1:0] remaining, start_cnt;
  logic           start_fire, in_fire, out_fire, last_limb;

  assign start_fire = start_valid && start_ready;
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid_q && out_ready;
  assign last_limb  = (remaining == LCW'(1));

  // A zero count still runs one limb; oversize counts clamp to the datapath depth.
  always_comb begin
    start_cnt = start_limbs;
    if (start_limbs == '0)                     start_cnt = LCW'(1);
    else if (start_limbs > LCW'(MAX_LIMBS))    start_cnt = LCW'(MAX_LIMBS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FLUSH exits on the drain even with on_off low, otherwise a drained block would stall.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_fire)             state_nxt = RUN;
      RUN:     if (in_fire && last_limb)   state_nxt = FLUSH;
      FLUSH:   if (out_fire)               state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_ready        = (state == IDLE) && on_off;
    in_ready           = (state == RUN) && on_off && (!out_valid_q || out_ready);
    adder_carry_listen = (state == RUN) && (sub_q || !first_q);
    adder_on_off       = on_off && (state == RUN);
  end

  assign adder_a        = in_a;
  assign adder_b        = sub_q ? ~in_b : in_b;
  assign adder_carry_in = carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q       <= '0;
      out_valid_q <= 1'b0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      first_q     <= 1'b0;
      remaining   <= '0;
    end else begin
      if (start_fire) begin
        sub_q     <= start_sub;
        carry_q   <= start_sub;
        first_q   <= 1'b1;
        remaining <= start_cnt;
      end
      // Subtract runs as A + ~B + 1, so the borrow is the inverted carry.
      if (in_fire) begin
        carry_q     <= adder_carry_out;
        first_q     <= 1'b0;
        remaining   <= remaining - LCW'(1);
        res_q.c     <= adder_c;
        res_q.last  <= last_limb;
        res_q.carry <= last_limb && (sub_q ^ adder_carry_out);
        out_valid_q <= 1'b1;
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_c     = res_q.c;
  assign out_last  = res_q.last;
  assign out_carry = res_q.carry;

endmodule

// File: tb/tb_carry_chain_sequencer.sv
// Directed bench for carry_chain_sequencer with a behavioural full_adder attached.
module tb_carry_chain_sequencer;
  localparam int W   = 16;
  localparam int ML  = 8;
  localparam int LCW = $clog2(ML + 1);

  logic clk = 1'b0, rst_n = 1'b0, on_off = 1'b1;
  logic start_valid = 1'b0, start_ready, start_sub = 1'b0;
  logic [LCW-1:0] start_limbs = '0;
  logic in_valid = 1'b0, in_ready;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic out_valid, out_ready = 1'b1, out_last, out_carry;
  logic [W-1:0] out_c, adder_a, adder_b, adder_c;
  logic adder_carry_in, adder_carry_listen, adder_on_off, adder_carry_out;

  int checks = 0, errors = 0;
  logic [W+1:0] res_q[$];
  logic [W:0]   fa_sum;

  carry_chain_sequencer #(.width(W), .MAX_LIMBS(ML)) dut (
    .clk(clk), .rst_n(rst_n), .on_off(on_off),
    .start_valid(start_valid), .start_ready(start_ready),
    .start_sub(start_sub), .start_limbs(start_limbs),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c),
    .out_last(out_last), .out_carry(out_carry),
    .adder_a(adder_a), .adder_b(adder_b), .adder_carry_in(adder_carry_in),
    .adder_carry_listen(adder_carry_listen), .adder_on_off(adder_on_off),
    .adder_c(adder_c), .adder_carry_out(adder_carry_out)
  );

  // Full adder model: carry_in only counts when carry_listen is high.
  assign fa_sum = {1'b0, adder_a} + {1'b0, adder_b} + {{W{1'b0}}, adder_carry_listen & adder_carry_in};
  assign adder_c         = adder_on_off ? fa_sum[W-1:0] : '0;
  assign adder_carry_out = adder_on_off & fa_sum[W];

  always #5 clk = ~clk;

  // Inputs change at posedge+1, so a handshake seen here fires on the next posedge.
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) res_q.push_back({out_c, out_last, out_carry});

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_op(input logic sub, input logic [LCW-1:0] n);
    bit ok = 1'b0;
    start_valid = 1'b1; start_sub = sub; start_limbs = n;
    for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); ok = start_ready; end
    checks++;
    if (!ok) begin errors++; $display("FAIL start_handshake: start_ready=0 required 1"); end
    tick();
    start_valid = 1'b0;
  endtask

  task automatic send_limb(input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b;
    for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); ok = in_ready; end
    checks++;
    if (!ok) begin errors++; $display("FAIL in_handshake: in_ready=0 required 1 (a=%h)", a); end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n);
    for (int i = 0; i < 50 && res_q.size() < n; i++) tick();
    tick();
    checks++;
    if (res_q.size() != n) begin
      errors++; $display("FAIL result_count: got %0d required %0d", res_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; on_off = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    checks++; if (out_c !== '0) begin errors++; $display("FAIL rst_out_c: got %h required 0000", out_c); end
    checks++; if ({out_last, out_carry} !== 2'b00) begin errors++; $display("FAIL rst_last_carry: got %b required 00", {out_last, out_carry}); end
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL rst_start_ready: got %b required 1", start_ready); end
    checks++; if ({in_ready, adder_on_off} !== 2'b00) begin errors++; $display("FAIL rst_in_ready_adder: got %b required 00", {in_ready, adder_on_off}); end
    tick(); rst_n = 1'b1; tick();
  endtask

  task automatic test_add2();
    logic [W+1:0] exp[2];
    exp[0] = {16'h0000, 1'b0, 1'b0};
    exp[1] = {16'h0002, 1'b1, 1'b0};
    res_q.delete();
    start_op(1'b0, LCW'(2));
    @(negedge clk);
    checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL add2_start_ready_run: got %b required 0", start_ready); end
    checks++; if ({adder_carry_listen, adder_on_off} !== 2'b01) begin errors++; $display("FAIL add2_first_listen: got %b required 01", {adder_carry_listen, adder_on_off}); end
    tick();
    send_limb(16'hFFFF, 16'h0001);
    send_limb(16'h0001, 16'h0000);
    wait_results(2);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (res_q[i] !== exp[i]) begin errors++; $display("FAIL add2_limb%0d: got %h required %h", i, res_q[i], exp[i]); end
    end
  endtask

  task automatic test_sub2();
    logic [W+1:0] exp[2];
    exp[0] = {16'hFFFF, 1'b0, 1'b0};
    exp[1] = {16'hFFFF, 1'b1, 1'b1};
    res_q.delete();
    start_op(1'b1, LCW'(2));
    send_limb(16'h0000, 16'h0001);
    send_limb(16'h0000, 16'h0000);
    wait_results(2);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (res_q[i] !== exp[i]) begin errors++; $display("FAIL sub2_limb%0d: got %h required %h", i, res_q[i], exp[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [W+1:0] exp[4];
    exp[0] = {16'h0000, 1'b0, 1'b0};
    exp[1] = {16'h0002, 1'b0, 1'b0};
    exp[2] = {16'h0005, 1'b0, 1'b0};
    exp[3] = {16'h0006, 1'b1, 1'b0};
    res_q.delete();
    start_op(1'b0, LCW'(4));
    send_limb(16'hFFFF, 16'h0001);
    send_limb(16'h0002, 16'hFFFF);
    out_ready = 1'b0; in_valid = 1'b1; in_a = 16'h0003; in_b = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_c%0d: got %b required 0", i, in_ready); end
      checks++; if ({out_valid, out_c, out_last} !== {1'b1, 16'h0002, 1'b0}) begin
        errors++; $display("FAIL bp_hold_c%0d: got v=%b c=%h l=%b required v=1 c=0002 l=0", i, out_valid, out_c, out_last);
      end
      tick();
    end
    out_ready = 1'b1;
    send_limb(16'h0003, 16'h0001);
    send_limb(16'h0004, 16'h0002);
    wait_results(4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res_q[i] !== exp[i]) begin errors++; $display("FAIL bp_limb%0d: got %h required %h", i, res_q[i], exp[i]); end
    end
  endtask

  task automatic test_on_off();
    logic [W+1:0] exp[2];
    exp[0] = {16'h0000, 1'b0, 1'b0};
    exp[1] = {16'h0002, 1'b1, 1'b0};
    res_q.delete();
    start_op(1'b0, LCW'(2));
    send_limb(16'hFFFF, 16'h0001);
    on_off = 1'b0; in_valid = 1'b1; in_a = 16'h0001; in_b = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if ({in_ready, adder_on_off, start_ready} !== 3'b000) begin
        errors++; $display("FAIL onoff_frozen_c%0d: got ir/aon/sr=%b required 000", i, {in_ready, adder_on_off, start_ready});
      end
      tick();
    end
    on_off = 1'b1;
    send_limb(16'h0001, 16'h0000);
    wait_results(2);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (res_q[i] !== exp[i]) begin errors++; $display("FAIL onoff_limb%0d: got %h required %h", i, res_q[i], exp[i]); end
    end
  endtask

  task automatic test_mid_reset();
    logic [W+1:0] exp[2];
    exp[0] = {16'h0000, 1'b0, 1'b0};
    exp[1] = {16'h0002, 1'b1, 1'b0};
    start_op(1'b0, LCW'(3));
    send_limb(16'hFFFF, 16'h0001);
    rst_n = 1'b0;
    #1;
    checks++; if ({out_valid, out_c, out_last, out_carry} !== '0) begin
      errors++; $display("FAIL mrst_outputs: got v=%b c=%h l=%b cy=%b required all 0", out_valid, out_c, out_last, out_carry);
    end
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL mrst_start_ready: got %b required 1", start_ready); end
    tick(); rst_n = 1'b1; tick();
    res_q.delete();
    in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h1111;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mrst_idle_in_ready: got %b required 0", in_ready); end
    tick(); in_valid = 1'b0;
    start_op(1'b0, LCW'(2));
    send_limb(16'hFFFF, 16'h0001);
    send_limb(16'h0001, 16'h0000);
    wait_results(2);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (res_q[i] !== exp[i]) begin errors++; $display("FAIL mrst_next_limb%0d: got %h required %h", i, res_q[i], exp[i]); end
    end
  endtask

  task automatic test_limb_count();
    logic [W+1:0] e;
    res_q.delete();
    start_op(1'b0, LCW'(0));
    send_limb(16'hFFFF, 16'h0001);
    wait_results(1);
    checks++;
    if (res_q[0] !== {16'h0000, 1'b1, 1'b1}) begin errors++; $display("FAIL zero_limbs: got %h required %h", res_q[0], {16'h0000, 1'b1, 1'b1}); end

    res_q.delete();
    start_op(1'b0, LCW'(ML + 3));
    for (int i = 0; i < ML; i++) send_limb(W'(i), W'(i + 1));
    wait_results(ML);
    for (int i = 0; i < ML; i++) begin
      e = {W'(2 * i + 1), (i == ML - 1), 1'b0};
      checks++;
      if (res_q[i] !== e) begin errors++; $display("FAIL sat_limb%0d: got %h required %h", i, res_q[i], e); end
    end
    in_valid = 1'b1; in_a = 16'h0001; in_b = 16'h0001;
    repeat (3) tick();
    checks++; if (res_q.size() != ML) begin errors++; $display("FAIL sat_extra_limb: got %0d results required %0d", res_q.size(), ML); end
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL sat_back_idle: got start_ready=%b required 1", start_ready); end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add2();
    test_sub2();
    test_backpressure();
    test_on_off();
    test_mid_reset();
    test_limb_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
